// File: rtl/instruction_memory_rom_if.sv
// Fetch/loader bus for the instruction store: combinational fetch read plus
// a synchronous write port used by a loader or debug host.
interface instruction_memory_rom_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24
);
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   modport master (
      output address,
      output wr_en,
      output wr_addr,
      output wr_data,
      input  data_out
   );

   modport slave (
      input  address,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      output data_out
   );
endinterface

// File: rtl/instruction_memory_rom.sv
// Word-addressed instruction store: zero-latency combinational read, rising-edge
// write port, and an asynchronous reset that reloads the default program image.
module instruction_memory_rom #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 256
) (
   input logic                     clk,
   input logic                     rst,
   instruction_memory_rom_if.slave mem_if
);
   // DEPTH <= 2**ADDR_WIDTH, so a word index never needs more than ADDR_WIDTH bits.
   localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return {1'b0, addr} < DEPTH_W;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] default_word(input int idx);
      case (idx)
         0:       return DATA_WIDTH'(24'h100001);
         1:       return DATA_WIDTH'(24'h110002);
         2:       return DATA_WIDTH'(24'h200100);
         3:       return DATA_WIDTH'(24'h300201);
         4:       return DATA_WIDTH'(24'h410003);
         5:       return DATA_WIDTH'(24'h500104);
         6:       return DATA_WIDTH'(24'h600000);
         7:       return DATA_WIDTH'(24'hF00000);
         default: return '0;
      endcase
   endfunction

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic                  wr_hit;

   // Out-of-range write addresses are dropped rather than aliased onto a word.
   assign wr_hit = mem_if.wr_en && in_range(mem_if.wr_addr);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      mem_d = mem_q;
      if (wr_hit) begin
         mem_d[mem_if.wr_addr[IDX_W-1:0]] = mem_if.wr_data;
      end
   end

   // The read is a pure mux on mem_q, so a write only shows up after its edge.
   always_comb begin
      mem_if.data_out = '0;
      if (in_range(mem_if.address)) begin
         mem_if.data_out = mem_q[mem_if.address[IDX_W-1:0]];
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      // NOTE: this array is a register file with a reset value per word because
      // reset must reload the program image; a plain RAM macro could not do this.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q[gi] <= default_word(gi);
         end else begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   end
endmodule

// File: tb/tb_instruction_memory_rom.sv
// Self-checking bench for instruction_memory_rom: directed image/write/reset
// steps followed by randomized traffic checked against an array model.
module tb_instruction_memory_rom;
   localparam int AW    = 8;
   localparam int DW    = 24;
   localparam int DEPTH = 256;

   localparam logic [DW-1:0] IMAGE [8] = '{
      24'h100001, 24'h110002, 24'h200100, 24'h300201,
      24'h410003, 24'h500104, 24'h600000, 24'hF00000
   };

   logic clk = 1'b0;
   logic rst = 1'b0;

   instruction_memory_rom_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   instruction_memory_rom #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .mem_if(bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [DW-1:0] model [DEPTH];

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < 8; i++) model[i] = IMAGE[i];
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) ? model[a] : '0;
   endfunction

   function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (int'(a) < DEPTH) model[a] = d;
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      #5 clk = 1'b1;
      #5 clk = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a);
      bus.address = a;
      #1;
      check(tag, bus.data_out, model_read(a));
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          we;

      bus.address = '0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;

      // Image sweep after a reset pulse, no clock edges at all.
      rst = 1'b1;
      #3 rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         bus.address = AW'(i);
         #20;
         check($sformatf("img[%0d]", i), bus.data_out, IMAGE[i]);
      end

      // Unprogrammed words read zero.
      bus.address = 8'h20;
      #1 check("addr_20", bus.data_out, 24'h000000);
      bus.address = 8'hFF;
      #1 check("addr_FF", bus.data_out, 24'h000000);

      // Read-during-write: old word before the edge, new word after it.
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'd3;
      bus.wr_data = 24'hABCDEF;
      bus.address = 8'd3;
      #1 check("rdw_before", bus.data_out, 24'h300201);
      tick();
      #1 check("rdw_after", bus.data_out, 24'hABCDEF);
      model_write(8'd3, 24'hABCDEF);
      bus.wr_en   = 1'b0;
      bus.address = 8'd4;
      #1 check("neighbour_4", bus.data_out, 24'h410003);

      // Disabled write leaves the word alone.
      bus.wr_addr = 8'd5;
      bus.wr_data = 24'h123456;
      tick();
      bus.address = 8'd5;
      #1 check("wr_en_low", bus.data_out, 24'h500104);

      // Asynchronous reset restores word 3 without a clock edge.
      bus.address = 8'd3;
      rst = 1'b1;
      #1 check("async_rst", bus.data_out, 24'h300201);

      // Write attempted while reset is held is ignored.
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'd3;
      bus.wr_data = 24'h555555;
      tick();
      #1 check("rst_blocks_wr", bus.data_out, 24'h300201);
      bus.address = 8'd6;
      #1 check("rst_img_6", bus.data_out, 24'h600000);
      bus.wr_en = 1'b0;
      rst       = 1'b0;
      model_reset();

      // Write then reset between edges discards the written word.
      bus.wr_en   = 1'b1;
      bus.wr_addr = 8'd40;
      bus.wr_data = 24'h0BEEF0;
      tick();
      model_write(8'd40, 24'h0BEEF0);
      bus.wr_en = 1'b0;
      read_check("mid_wr_40", 8'd40);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      model_reset();
      read_check("mid_rst_40", 8'd40);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
            model_reset();
            read_check("rnd_rst", AW'($urandom_range(0, 15)));
         end else begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            d  = DW'($urandom);
            bus.wr_en   = we;
            bus.wr_addr = a;
            bus.wr_data = d;
            bus.address = ($urandom_range(0, 1) == 0) ? a : AW'($urandom);
            #1 check("rnd_pre", bus.data_out, model_read(bus.address));
            tick();
            if (we) model_write(a, d);
            #1 check("rnd_post", bus.data_out, model_read(bus.address));
         end
      end
      bus.wr_en = 1'b0;

      // Full sweep: every word matches the model and carries no X.
      for (int i = 0; i < DEPTH; i++) begin
         read_check($sformatf("sweep[%0d]", i), AW'(i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
